// File: rtl/wb_fake_slave.sv
// Pipelined WISHBONE responder model: word-addressed memory behind a fixed-latency
// ACK/ERR pipeline, with programmable STALL back-pressure for exercising bus masters.

`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef BUS_SEL_WIDTH
`define BUS_SEL_WIDTH 4
`endif

module wb_fake_slave #(
    parameter int unsigned MEM_DEPTH    = 16,
    parameter int unsigned ACK_LATENCY  = 2,
    parameter int unsigned STALL_EVERY  = 0,
    parameter int unsigned STALL_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          CYC_I,
    input  logic                          STB_I,
    input  logic                          WE_I,
    input  logic [`BUS_ADDRESS_WIDTH-1:0] ADR_I,
    input  logic [`BUS_DATA_WIDTH-1:0]    DAT_I,
    input  logic [`BUS_SEL_WIDTH-1:0]     SEL_I,
    input  logic [2:0]                    CTI_I,
    output logic [`BUS_DATA_WIDTH-1:0]    DAT_O,
    output logic                          ACK_O,
    output logic                          ERR_O,
    output logic                          RTY_O,
    output logic                          STALL_O
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned DW = `BUS_DATA_WIDTH;
    localparam int unsigned SW = (STALL_EVERY > 0) ? $clog2(STALL_EVERY + 1) : 1;
    localparam int unsigned CW = $clog2(STALL_CYCLES + 1);
    localparam int unsigned LAST = ACK_LATENCY - 1;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    typedef struct packed {
        logic          valid;
        logic          is_err;
        logic [DW-1:0] data;
    } resp_t;

    state_t        state;
    state_t        state_d;
    logic          flush_c;

    logic [DW-1:0] mem [MEM_DEPTH];
    resp_t         pipe [ACK_LATENCY];
    resp_t         resp_c;

    logic [AW-1:0] beat;
    logic [AW-1:0] idx_c;
    logic [SW-1:0] scnt;
    logic [CW-1:0] stall_cnt;
    logic          stall_q;
    logic          acc_c;
    logic          sel_ok_c;
    logic          unused;

    assign acc_c    = CYC_I & STB_I & ~stall_q;
    assign sel_ok_c = &SEL_I;
    assign idx_c    = ADR_I[AW-1:0] + beat;
    assign unused   = ^{CTI_I, ADR_I};

    // Bus-cycle tracking; leaving ACTIVE flushes in-flight responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        flush_c = 1'b0;
        case (state)
            IDLE: begin
                if (CYC_I) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (!CYC_I) begin
                    state_d = IDLE;
                    flush_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response for the beat being accepted this cycle.
    always_comb begin
        resp_c        = '0;
        resp_c.valid  = acc_c;
        resp_c.is_err = acc_c & ~sel_ok_c;
        if (acc_c && !WE_I && sel_ok_c) begin
            resp_c.data = mem[idx_c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (acc_c && WE_I && sel_ok_c) begin
            mem[idx_c] <= DAT_I;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_c) begin
            for (int i = 0; i < ACK_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= resp_c;
            for (int i = 1; i < ACK_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !CYC_I) begin
            beat <= '0;
        end else if (acc_c) begin
            beat <= beat + AW'(1);
        end
    end

    // Stall generator: after STALL_EVERY accepted beats, hold STALL_O for STALL_CYCLES.
    always_ff @(posedge clk) begin
        if (rst || !CYC_I || STALL_EVERY == 0) begin
            stall_q   <= 1'b0;
            scnt      <= '0;
            stall_cnt <= '0;
        end else if (stall_q) begin
            if (stall_cnt == CW'(1)) begin
                stall_q   <= 1'b0;
                scnt      <= '0;
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt - CW'(1);
            end
        end else if (acc_c) begin
            scnt <= scnt + SW'(1);
            if (scnt + SW'(1) == SW'(STALL_EVERY)) begin
                stall_q   <= 1'b1;
                stall_cnt <= CW'(STALL_CYCLES);
            end
        end
    end

    assign ACK_O   = pipe[LAST].valid & ~pipe[LAST].is_err;
    assign ERR_O   = pipe[LAST].valid & pipe[LAST].is_err;
    assign DAT_O   = pipe[LAST].data;
    assign RTY_O   = 1'b0;
    assign STALL_O = stall_q;

endmodule

// File: tb/tb_wb_fake_slave.sv
// Scoreboard bench for wb_fake_slave: two instances (plain L=2, and L=3 with stalls)
// driven by directed bus cycles; a negedge monitor pops expected responses.

`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef BUS_SEL_WIDTH
`define BUS_SEL_WIDTH 4
`endif

module tb_wb_fake_slave;

    localparam int unsigned AWID = `BUS_ADDRESS_WIDTH;
    localparam int unsigned DW   = `BUS_DATA_WIDTH;
    localparam int unsigned SELW = `BUS_SEL_WIDTH;
    localparam int L0 = 2;
    localparam int L1 = 3;

    typedef struct {
        logic          is_err;
        logic [DW-1:0] dat;
        int            due;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            cyc   [2];
    logic            stb   [2];
    logic            we    [2];
    logic [AWID-1:0] adr   [2];
    logic [DW-1:0]   dati  [2];
    logic [DW-1:0]   dato  [2];
    logic [SELW-1:0] sel   [2];
    logic [2:0]      cti   [2];
    logic            ack   [2];
    logic            err   [2];
    logic            rty   [2];
    logic            stall [2];

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   stall_hi1 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    wb_fake_slave #(.MEM_DEPTH(16), .ACK_LATENCY(L0), .STALL_EVERY(0), .STALL_CYCLES(1)) u0 (
        .clk(clk), .rst(rst), .CYC_I(cyc[0]), .STB_I(stb[0]), .WE_I(we[0]), .ADR_I(adr[0]),
        .DAT_I(dati[0]), .SEL_I(sel[0]), .CTI_I(cti[0]), .DAT_O(dato[0]), .ACK_O(ack[0]),
        .ERR_O(err[0]), .RTY_O(rty[0]), .STALL_O(stall[0])
    );

    wb_fake_slave #(.MEM_DEPTH(16), .ACK_LATENCY(L1), .STALL_EVERY(2), .STALL_CYCLES(3)) u1 (
        .clk(clk), .rst(rst), .CYC_I(cyc[1]), .STB_I(stb[1]), .WE_I(we[1]), .ADR_I(adr[1]),
        .DAT_I(dati[1]), .SEL_I(sel[1]), .CTI_I(cti[1]), .DAT_O(dato[1]), .ACK_O(ack[1]),
        .ERR_O(err[1]), .RTY_O(rty[1]), .STALL_O(stall[1])
    );

    task automatic mon(input int d);
        exp_t x;
        int   n;
        checks++;
        if (ack[d] || err[d]) begin
            n = (d == 0) ? q0.size() : q1.size();
            if (n == 0) begin
                errors++;
                $display("FAIL unexpected_resp dut%0d edge %0d: got ack=%0b err=%0b dat=%h, required no response",
                         d, edge_cnt, ack[d], err[d], dato[d]);
            end else begin
                if (d == 0) x = q0.pop_front();
                else        x = q1.pop_front();
                if (ack[d] !== !x.is_err || err[d] !== x.is_err || dato[d] !== x.dat || edge_cnt != x.due) begin
                    errors++;
                    $display("FAIL resp dut%0d: got ack=%0b err=%0b dat=%h edge=%0d, required ack=%0b err=%0b dat=%h edge=%0d",
                             d, ack[d], err[d], dato[d], edge_cnt, !x.is_err, x.is_err, x.dat, x.due);
                end
            end
        end else if (dato[d] !== '0 || rty[d] !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs dut%0d edge %0d: got dat=%h rty=%0b, required 0", d, edge_cnt, dato[d], rty[d]);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0);
            mon(1);
        end
        if (stall[1]) stall_hi1++;
    end

    function automatic int lat(input int d);
        return (d == 0) ? L0 : L1;
    endfunction

    // One beat: present it, wait out STALL_O, then log the expected response.
    task automatic beat(input int d, input bit w, input logic [AWID-1:0] a, input logic [DW-1:0] dv,
                        input logic [SELW-1:0] s, input bit push, input bit e, input logic [DW-1:0] exp_d);
        int   n;
        exp_t x;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dati[d] = dv; sel[d] = s;
        n = 0;
        while (stall[d] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (stall[d]) begin
            checks++; errors++;
            $display("FAIL stall_timeout dut%0d: got STALL_O=1 after %0d cycles, required release", d, n);
        end
        @(posedge clk); #1;
        if (push) begin
            x.is_err = e;
            x.dat    = exp_d;
            x.due    = edge_cnt + lat(d) - 1;
            if (d == 0) q0.push_back(x);
            else        q1.push_back(x);
        end
    endtask

    task automatic end_cycle(input int d);
        stb[d] = 1'b0;
        repeat (lat(d)) @(posedge clk);
        #1;
        cyc[d] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input int d, input logic [AWID-1:0] a, input logic [DW-1:0] v);
        beat(d, 1'b1, a, v, '1, 1'b1, 1'b0, '0);
        end_cycle(d);
    endtask

    task automatic rd(input int d, input logic [AWID-1:0] a, input logic [DW-1:0] v);
        beat(d, 1'b0, a, '0, '1, 1'b1, 1'b0, v);
        end_cycle(d);
    endtask

    task automatic check_zero(input int d, input string name);
        checks++;
        if ({ack[d], err[d], rty[d], stall[d], dato[d]} !== '0) begin
            errors++;
            $display("FAIL %s dut%0d: got ack=%0b err=%0b rty=%0b stall=%0b dat=%h, required all 0",
                     name, d, ack[d], err[d], rty[d], stall[d], dato[d]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    initial begin
        int s0;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; adr[d] = '0;
            dati[d] = '0; sel[d] = '1; cti[d] = 3'b000;
        end
        repeat (3) @(posedge clk);
        #1;
        check_zero(0, "reset_outputs");
        check_zero(1, "reset_outputs");
        rst = 1'b0;

        // Single write then read, latency 2.
        wr(0, 3, 32'hA5A5_A5A5);
        rd(0, 3, 32'hA5A5_A5A5);

        // Wrapping write burst 14..1, then read burst back.
        for (int i = 0; i < 4; i++) beat(0, 1'b1, 14, DW'(i + 1), '1, 1'b1, 1'b0, '0);
        end_cycle(0);
        for (int i = 0; i < 4; i++) beat(0, 1'b0, 14, '0, '1, 1'b1, 1'b0, DW'(i + 1));
        end_cycle(0);
        rd(0, 0, 32'd3);
        rd(0, 1, 32'd4);

        // Invalid byte selects give ERR and leave memory untouched.
        wr(0, 5, 32'h11);
        beat(0, 1'b1, 5, 32'hFF, '0, 1'b1, 1'b1, '0);
        end_cycle(0);
        rd(0, 5, 32'h11);

        // Read-after-write to the same index on consecutive beats.
        beat(0, 1'b1, 6, 32'h77, '1, 1'b1, 1'b0, '0);
        beat(0, 1'b0, 5, '0, '1, 1'b1, 1'b0, 32'h77);
        end_cycle(0);

        // Stalling instance: two stalls of 3 cycles per 4-beat burst.
        s0 = stall_hi1;
        for (int i = 0; i < 4; i++) beat(1, 1'b1, 8, DW'(i + 1), '1, 1'b1, 1'b0, '0);
        end_cycle(1);
        check_int("stall_cycles_write_burst", stall_hi1 - s0, 6);
        s0 = stall_hi1;
        for (int i = 0; i < 4; i++) beat(1, 1'b0, 8, '0, '1, 1'b1, 1'b0, DW'(i + 1));
        end_cycle(1);
        check_int("stall_cycles_read_burst", stall_hi1 - s0, 6);

        // Abort after two beats: nothing may come back.
        beat(1, 1'b0, 8, '0, '1, 1'b0, 1'b0, '0);
        beat(1, 1'b0, 8, '0, '1, 1'b0, 1'b0, '0);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_zero(1, "after_abort");
        for (int i = 0; i < 2; i++) beat(1, 1'b0, 8, '0, '1, 1'b1, 1'b0, DW'(i + 1));
        end_cycle(1);

        // Reset with a beat in flight.
        beat(0, 1'b1, 9, 32'h99, '1, 1'b0, 1'b0, '0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero(0, "mid_burst_reset");
        rst = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
        @(posedge clk); #1;
        rd(0, 3, '0);
        rd(0, 9, '0);
        rd(0, 14, '0);

        repeat (6) @(posedge clk);
        #1;
        check_int("pending_dut0", q0.size(), 0);
        check_int("pending_dut1", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_fake_slave.md
# wb_fake_slave

Pipelined WISHBONE slave model for NIC test benches: the responder end of the bus driven by the NIC's fake master and its bus-side interface. It accepts single and burst write/read cycles into a small word-addressed memory. It inserts programmable STALL back-pressure and returns ACK/ERR with read data after a fixed latency. Its purpose is to exercise the master-side handshakes and pipelining of the NIC.

## Interface
Parameters:
- MEM_DEPTH, 16: number of `BUS_DATA_WIDTH words; power of 2, at least 2. AW = log2(MEM_DEPTH).
- ACK_LATENCY, 2: number of clock edges from beat acceptance to its response; minimum 1.
- STALL_EVERY, 0: 0 means never stall; N means stall after every N accepted beats.
- STALL_CYCLES, 1: number of cycles STALL_O stays high per stall event; minimum 1.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- CYC_I  in  1  bus cycle active.
- STB_I  in  1  beat strobe.
- WE_I  in  1  1 = write, 0 = read.
- ADR_I  in  `BUS_ADDRESS_WIDTH  burst base word address; only [AW-1:0] is used.
- DAT_I  in  `BUS_DATA_WIDTH  write data.
- SEL_I  in  `BUS_SEL_WIDTH  byte selects; only all-ones is supported.
- CTI_I  in  3  ignored.
- DAT_O  out  `BUS_DATA_WIDTH  read data; valid only while ACK_O is high, 0 otherwise.
- ACK_O  out  1  beat completed.
- ERR_O  out  1  beat rejected.
- RTY_O  out  1  tied 0.
- STALL_O  out  1  registered back-pressure.

## Operation
- Accept condition: acc = CYC_I & STB_I & !STALL_O. At most one beat is accepted per cycle.
- Beat counter `beat` has AW bits. It clears while CYC_I = 0 and increments on each acc.
- Memory index: idx = (ADR_I[AW-1:0] + beat) mod MEM_DEPTH. The index wraps silently past MEM_DEPTH-1.
- Valid beat (SEL_I all ones):
  - Write: mem[idx] <= DAT_I at the accepting edge.
  - Read: mem[idx] is captured at the accepting edge.
  - Response type is ACK.
- Invalid SEL_I: no memory write; response type is ERR with data 0.
- Response pipeline: a shift register ACK_LATENCY deep, each stage holding {valid, is_err, data}. The last stage drives ACK_O = valid & !is_err, ERR_O = valid & is_err, and DAT_O.
- FSM:
  - IDLE (CYC_I = 0) -> ACTIVE on CYC_I = 1.
  - ACTIVE -> IDLE on CYC_I = 0.
  - On CYC_I falling (abort or normal end), all pipeline stages are invalidated on the same edge. No ACK/ERR is issued while CYC_I = 0.
- Stall generator (active only if STALL_EVERY > 0):
  - `scnt` counts acc.
  - When an acc makes scnt = STALL_EVERY, STALL_O goes high from the next cycle for STALL_CYCLES cycles, then scnt clears.
  - STALL_O is forced to 0 and scnt is cleared while CYC_I = 0.
- Reset: memory cleared to 0; beat, scnt and pipeline cleared; FSM to IDLE.

## Timing
- Reset values: ACK_O = 0, ERR_O = 0, RTY_O = 0, STALL_O = 0, DAT_O = 0.
- A beat accepted at edge k is answered on ACK_O/ERR_O during the cycle that follows edge k+ACK_LATENCY-1. With ACK_LATENCY = 1 the response appears in the cycle right after acceptance.
- Back-to-back beats get back-to-back responses, in acceptance order, one per cycle.
- Read-after-write to the same idx in consecutive beats returns the new data, because the write is committed at the earlier edge.
- STALL_O high with STB_I high: no acceptance, beat does not advance, and the master must hold its outputs.
- Responses already in the pipeline continue to shift out while STALL_O is high.
- rst during a burst: on the next cycle all outputs are 0 and in-flight responses are discarded.
- Simultaneous acc and CYC_I falling cannot occur, because acc requires CYC_I = 1.

## Test plan
- Single write then read, ACK_LATENCY = 2:
  - Write ADR = 3, DAT = 0xA5A5A5A5.
  - New cycle: read ADR = 3.
  - Expect ACK 2 cycles after each accepted beat and DAT_O = 0xA5A5A5A5.
- 4-beat write burst at ADR = 14 with MEM_DEPTH = 16, data 1..4; then read burst of 4 from ADR = 14.
  - Expect mem[14] = 1, mem[15] = 2, mem[0] = 3, mem[1] = 4 (wrap-around).
  - Expect read ACKs to return 1, 2, 3, 4 in order on consecutive cycles.
- STALL_EVERY = 2, STALL_CYCLES = 3, 4-beat write burst:
  - Expect STALL_O high for 3 cycles after beats 2 and 4.
  - Expect the beat counter to hold during stall and exactly 4 ACKs.
- SEL_I = 0 on a write to ADR = 5 holding 0x11:
  - Expect ERR_O pulse, no ACK_O, and mem[5] still 0x11 on a later read.
- Abort: 4-beat read burst with CYC_I dropped after beat 2 is accepted (ACK_LATENCY = 3):
  - Expect no ACK_O/ERR_O after CYC_I falls.
  - Expect the next cycle to start from beat 0.
- rst asserted mid-burst:
  - Expect all outputs 0 on the following cycle.
  - Expect a subsequent read of any address to return 0.
